dsc_sng_seq: RTL
================

DSC_SNG_SEQ -- requirements
Module: dsc_sng_seq

Interface
REQ-001 Parameter WIDTH, default 4; operand and SNG counter width in bits.
REQ-002 Parameter STRIDE, default 1, legal values 1, 2 or 4; stream bits produced by the SNG per cycle.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low. Ports are named clk and rst, with rst low meaning reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand offered.
REQ-007 in_ready  output  1  controller can accept an operand.
REQ-008 in_data  input  WIDTH  binary operand.
REQ-009 sng_bin  output  WIDTH  registered operand driven to the SNG bin_in.
REQ-010 sng_en  output  1  SNG counter enable.
REQ-011 sng_clr  output  1  synchronous active-high SNG counter clear.
REQ-012 sng_sn  input  STRIDE  stream bits returned by the SNG.
REQ-013 sng_ovf  input  1  SNG counter overflow.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 out_data  output  WIDTH+1  count of ones over one full stream.
REQ-017 err  output  1  sticky overflow/beat mismatch flag.
REQ-018 abort  input  1  cancel the current operation; present only with DSC_SEQ_ABORT_EN.

Function
REQ-019 FSM states: IDLE, CLEAR, RUN, DONE.
REQ-020 IDLE:
- in_ready=1.
- When in_valid&in_ready, latch in_data into sng_bin and go to CLEAR.
REQ-021 CLEAR lasts exactly one cycle:
- sng_clr=1, sng_en=0.
- accumulator cleared to 0.
- beat counter loaded with N-1, where N = 2^WIDTH/STRIDE.
- next state RUN.
REQ-022 RUN lasts exactly N cycles:
- sng_en=1.
- each cycle the accumulator adds popcount(sng_sn) and the beat counter decrements.
- on the cycle the beat counter is 0, go to DONE.
REQ-023 On the final RUN cycle sng_ovf must be 1, and it must be 0 on every earlier RUN cycle. Any violation sets err, which stays 1 until reset. The sequence still completes with N beats.
REQ-024 DONE:
- out_valid=1 and out_data holds the accumulator, stable until out_valid&out_ready.
- on that handshake go to IDLE.
REQ-025 in_ready=0 in CLEAR, RUN and DONE. No operand is accepted until the result has been taken; there is no same-cycle bypass from DONE to CLEAR.
REQ-026 Latency: handshake in cycle T gives CLEAR at T+1, RUN at T+2..T+1+N, and out_valid first high at T+2+N.
REQ-027 Accumulator width is WIDTH+1 and cannot wrap; the maximum count is 2^WIDTH.
REQ-028 sng_en=0 and sng_clr=0 in IDLE and DONE.

Reset
REQ-029 Reset values:
- state=IDLE, in_ready=1.
- out_valid=0, out_data=0, sng_bin=0.
- sng_en=0, sng_clr=0.
- err=0, accumulator and beat counter 0.
REQ-030 Reset asserted in any state, including mid-RUN, discards the operation immediately. No result is emitted after reset releases.

Configuration
REQ-031 Macro DSC_SEQ_ABORT_EN.
- Defined: the abort port exists. abort=1 in CLEAR or RUN returns the FSM to IDLE next cycle, with sng_en=0, no out_valid and err unchanged. abort has no effect in IDLE or DONE.
- Undefined: no abort port and no abort logic.

Structure
REQ-032 Shared package dsc_pkg holds:
- the state enum type for IDLE/CLEAR/RUN/DONE.
- a popcount function for up to 4 bits.
- the constant function for N derived from WIDTH and STRIDE.
REQ-033 One sub-module, dsc_beat_ctr: a down-counter with load, decrement and zero flag, used for the beat count. Everything else is flat.

Verification
REQ-034 All scenarios run with a real sng_dsc attached to the sng_* ports.
REQ-035 Scenarios:
- Basic, WIDTH=4, STRIDE=1: operand 5 → out_data=5, out_valid first high 18 cycles after the input handshake, err=0.
- Extremes, WIDTH=4, STRIDE=1: operand 0 → out_data=0; operand 15 → out_data=15; both with err=0.
- Wide stride, WIDTH=4, STRIDE=4: operand 9 → RUN lasts 4 cycles, out_data=9, out_valid 6 cycles after the handshake.
- Backpressure: out_ready held 0 for 10 cycles in DONE → out_data stable, in_ready=0 and a new in_valid is ignored. Release → result accepted and in_ready=1 next cycle.
- Reset mid-operation: rst low at RUN beat 7 → all outputs at reset values immediately. After release, no out_valid appears and a new operand 3 yields 3.
- Overflow mismatch: force sng_ovf=1 at RUN beat 2 → err=1 and stays 1. The result is still delivered after 16 beats. With DSC_SEQ_ABORT_EN, abort at beat 4 → IDLE next cycle and no out_valid.

Source files
------------

// File: rtl/dsc_pkg.sv
// Shared types and helpers for the DSC stochastic-stream sequencer:
// FSM state type, a popcount of up to four stream bits, and the stream beat count.
package dsc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] bits);
        logic [2:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum = sum + {2'b00, bits[i]};
        end
        return sum;
    endfunction

    // Cycles needed for the SNG to sweep its whole counter range.
    function automatic int unsigned beats_per_stream(input int unsigned width,
                                                     input int unsigned stride);
        return (32'd1 << width) / stride;
    endfunction

endpackage

// File: rtl/dsc_beat_ctr.sv
// Down-counter with load, decrement and zero flag; it tracks the remaining RUN beats.
module dsc_beat_ctr #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    always_comb begin
        zero = (cnt_q == '0);
    end

endmodule

// File: rtl/dsc_sng_seq.sv
// Sequencer that runs one attached SNG over a full stream and counts the ones it returns.
// Optional feature: define DSC_SEQ_ABORT_EN to add an abort input that cancels CLEAR/RUN.
module dsc_sng_seq
    import dsc_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic [WIDTH-1:0]  sng_bin,
    output logic              sng_en,
    output logic              sng_clr,
    input  logic [STRIDE-1:0] sng_sn,
    input  logic              sng_ovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    out_data,
    output logic              err
`ifdef DSC_SEQ_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam int unsigned      N         = beats_per_stream(WIDTH, STRIDE);
    localparam logic [WIDTH-1:0] LAST_BEAT = WIDTH'(N - 1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH:0]   acc_q;
    logic             err_q;
    logic             beat_zero;
    logic             cancel;
    logic             ctr_load;
    logic [3:0]       sn_pad;

`ifdef DSC_SEQ_ABORT_EN
    always_comb begin
        cancel = abort;
    end
`else
    always_comb begin
        cancel = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        sng_en    = 1'b0;
        sng_clr   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                sng_clr = 1'b1;
                state_d = cancel ? IDLE : RUN;
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    sng_en = 1'b1;
                    if (beat_zero) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stream bits are zero-extended so one 4-bit popcount covers every legal STRIDE.
    always_comb begin
        sn_pad               = '0;
        sn_pad[STRIDE-1:0]   = sng_sn;
        ctr_load             = (state_q == CLEAR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q <= '0;
            acc_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                bin_q <= in_data;
            end
            if (ctr_load) begin
                acc_q <= '0;
            end else if (sng_en) begin
                acc_q <= acc_q + (WIDTH + 1)'(popcount4(sn_pad));
            end
            // Overflow must coincide with the last beat exactly; anything else is sticky.
            if (sng_en && (sng_ovf != beat_zero)) begin
                err_q <= 1'b1;
            end
        end
    end

    dsc_beat_ctr #(
        .WIDTH (WIDTH)
    ) u_beat_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (LAST_BEAT),
        .dec      (sng_en),
        .zero     (beat_zero)
    );

    always_comb begin
        sng_bin  = bin_q;
        out_data = acc_q;
        err      = err_q;
    end

endmodule
